// File: rtl/audio_delay_pkg.sv
// Shared audio types and saturation helper for the effects-chain stages,
// plus the echo stage's FSM encoding.
package audio_delay_pkg;

   typedef logic signed [15:0] sample_t;

   localparam sample_t SAMPLE_MAX = 16'sh7FFF;
   localparam sample_t SAMPLE_MIN = 16'sh8000;

   typedef enum logic [2:0] {CLEAR, IDLE, RD_WAIT, MIX, WRITE} state_t;

   function automatic sample_t sat16(logic signed [17:0] v);
      if (v > 18'sd32767)  return SAMPLE_MAX;
      if (v < -18'sd32768) return SAMPLE_MIN;
      return v[15:0];
   endfunction

endpackage

// File: rtl/audio_delay_if.sv
// Sample stream, pot inputs and busy flag of the echo stage.
interface audio_delay_if;
   import audio_delay_pkg::*;

   logic [9:0] pot_delay;
   logic [9:0] pot_feedback;
   logic [9:0] pot_wet;
   sample_t    sample_in;
   logic       sample_in_valid;
   sample_t    sample_out;
   logic       sample_out_valid;
   logic       busy;

   modport master (
      output pot_delay, pot_feedback, pot_wet, sample_in, sample_in_valid,
      input  sample_out, sample_out_valid, busy
   );

   modport slave (
      input  pot_delay, pot_feedback, pot_wet, sample_in, sample_in_valid,
      output sample_out, sample_out_valid, busy
   );

endinterface

// File: rtl/audio_delay_delay_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered output (2-cycle read latency).
module delay_ram
   import audio_delay_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  sample_t           wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output sample_t           rd_data
);

   sample_t mem [2**ADDR_W];
   sample_t rd_q_p0;

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      // array read stage, then output register stage
      rd_q_p0 <= mem[rd_addr];
      rd_data <= rd_q_p0;
   end

endmodule

// File: rtl/audio_delay.sv
// Feedback echo: output = dry + wet-scaled delayed copy; the buffer stores
// dry + feedback-scaled delayed copy.
module audio_delay
   import audio_delay_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input logic         clk,
   input logic         rst_n,
   audio_delay_if.slave bus
);

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] wr_ptr;
   logic              wait_cnt;

   sample_t           x_p0;
   logic [7:0]        fb_p0;
   logic [7:0]        w_p0;
   logic [ADDR_W-1:0] rd_addr_p0;
   sample_t           rd_data;
   sample_t           fbk_p2;
   sample_t           y_p2;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   sample_t           ram_wdata;

   function automatic logic [ADDR_W-1:0] delay_len(logic [9:0] pot);
      if (pot == 10'd0) return ADDR_W'(1);
      return ADDR_W'(pot) << (ADDR_W - 10);
   endfunction

   // Gain is unsigned Q0.8; the arithmetic shift floors toward -inf.
   function automatic sample_t mix(sample_t x, sample_t d, logic [7:0] g);
      logic signed [24:0] prod;
      logic signed [17:0] sum;
      prod = 25'(d) * 25'($signed({1'b0, g}));
      sum  = 18'(x) + 18'(prod >>> 8);
      return sat16(sum);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (clr_addr == '1) state_next = IDLE;
         IDLE:    if (bus.sample_in_valid) state_next = RD_WAIT;
         RD_WAIT: if (wait_cnt) state_next = MIX;
         MIX:     state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = CLEAR;
      endcase
   end

   always_comb begin
      bus.busy  = (state != IDLE);
      ram_we    = 1'b0;
      ram_addr  = wr_ptr;
      ram_wdata = '0;
      case (state)
         CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
         end
         WRITE: begin
            ram_we    = 1'b1;
            ram_wdata = fbk_p2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_addr             <= '0;
         wr_ptr               <= '0;
         wait_cnt             <= 1'b0;
         bus.sample_out       <= '0;
         bus.sample_out_valid <= 1'b0;
      end else begin
         bus.sample_out_valid <= (state == WRITE);
         wait_cnt             <= (state == RD_WAIT) ? ~wait_cnt : 1'b0;
         if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
         if (state == WRITE) begin
            wr_ptr         <= wr_ptr + 1'b1;
            bus.sample_out <= y_p2;
         end
      end
   end

   // p0: capture sample and pots on acceptance; p2: mix result after read
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.sample_in_valid) begin
         x_p0       <= bus.sample_in;
         fb_p0      <= bus.pot_feedback[9:2];
         w_p0       <= bus.pot_wet[9:2];
         rd_addr_p0 <= wr_ptr - delay_len(bus.pot_delay);
      end
      if (state == MIX) begin
         fbk_p2 <= mix(x_p0, rd_data, fb_p0);
         y_p2   <= mix(x_p0, rd_data, w_p0);
      end
   end

   delay_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_addr (ram_addr),
      .wr_data (ram_wdata),
      .rd_addr (rd_addr_p0),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_audio_delay.sv
// Scoreboard bench for audio_delay: directed echo/saturation cases plus
// randomized traffic against an arithmetic reference model of the echo.
module tb_audio_delay;

   localparam int AW    = 12;
   localparam int NB    = 1 << AW;
   localparam int SCALE = NB / 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   audio_delay_if bus();

   audio_delay #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [15:0] y;
      int          due;
   } exp_t;
   exp_t sb[$];

   int mbuf [NB];
   int mptr;
   int pd, pf, pw;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   task automatic checkint(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   function automatic int floor_div256(int v);
      return (v >= 0) ? v / 256 : -((255 - v) / 256);
   endfunction

   function automatic int clamp(int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Echo model: one buffer slot per sample, written with the feedback mix.
   function automatic logic [15:0] model_step(int x);
      int dl, d, fbk, y;
      dl  = (pd == 0) ? 1 : pd * SCALE;
      d   = mbuf[(mptr - dl + NB) % NB];
      fbk = clamp(x + floor_div256(d * (pf / 4)));
      y   = clamp(x + floor_div256(d * (pw / 4)));
      mbuf[mptr] = fbk;
      mptr = (mptr + 1) % NB;
      return y[15:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.sample_out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_output: got sample_out=%h, required no output", bus.sample_out);
         end else begin
            e = sb.pop_front();
            check16("sample_out", bus.sample_out, e.y);
            checkint("latency_cycle", cyc, e.due);
         end
      end
   end

   task automatic send(input int x, input bit use_c, input logic [15:0] c);
      logic signed [15:0] xs;
      exp_t e;
      xs = x[15:0];
      bus.sample_in       = xs;
      bus.pot_delay       = pd[9:0];
      bus.pot_feedback    = pf[9:0];
      bus.pot_wet         = pw[9:0];
      bus.sample_in_valid = 1'b1;
      e.y = model_step(int'(xs));
      if (use_c) e.y = c;
      e.due = cyc + 5;
      sb.push_back(e);
      @(negedge clk);
      bus.sample_in_valid = 1'b0;
      // pots and input wander while the sample is in flight
      bus.pot_delay    = 10'($urandom);
      bus.pot_feedback = 10'($urandom);
      bus.pot_wet      = 10'($urandom);
      bus.sample_in    = 16'($urandom);
      repeat (4) @(negedge clk);
   endtask

   task automatic sat_seq(input int x0, input int x1, input logic [15:0] c);
      send(x0, 1'b0, 16'h0);
      for (int i = 0; i < 15; i++) send(0, 1'b0, 16'h0);
      send(x1, 1'b1, c);
   endtask

   task automatic do_reset(input bit strobe);
      int cnt;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      sb.delete();
      check16("rst_sample_out", bus.sample_out, 16'h0);
      checkint("rst_out_valid", int'(bus.sample_out_valid), 0);
      checkint("rst_busy", int'(bus.busy), 1);
      for (int i = 0; i < NB; i++) mbuf[i] = 0;
      mptr  = 0;
      rst_n = 1'b1;
      cnt   = 0;
      while (bus.busy === 1'b1 && cnt < NB + 64) begin
         bus.sample_in       = 16'sh5555;
         bus.sample_in_valid = strobe && (cnt == 100);
         cnt++;
         @(negedge clk);
      end
      bus.sample_in_valid = 1'b0;
      checkint("clear_busy_cycles", cnt, NB);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] c;
      int w;
      bus.sample_in       = '0;
      bus.sample_in_valid = 1'b0;
      bus.pot_delay       = '0;
      bus.pot_feedback    = '0;
      bus.pot_wet         = '0;
      pd = 0; pf = 0; pw = 0;

      do_reset(1'b1);

      // impulse echo at 16 samples, no feedback
      pd = 16 / SCALE; pf = 0; pw = 1023;
      for (int k = 0; k < 24; k++) begin
         c = (k == 0) ? 16'h4000 : (k == 16) ? 16'h3FC0 : 16'h0000;
         send((k == 0) ? 'h4000 : 0, 1'b1, c);
      end

      // feedback decay
      pf = 1023;
      for (int j = 0; j < 49; j++) begin
         case (j)
            0:       c = 16'h4000;
            16:      c = 16'h3FC0;
            32:      c = 16'h3F80;
            48:      c = 16'h3F40;
            default: c = 16'h0000;
         endcase
         send((j == 0) ? 'h4000 : 0, 1'b1, c);
      end

      // saturation and floor rounding
      pf = 0; pw = 1023;
      sat_seq('h7000, 'h7000, 16'h7FFF);
      sat_seq('h9000, 'h9000, 16'h8000);
      sat_seq('hFFFF, 0, 16'hFFFF);

      for (int n = 0; n < 200; n++) begin
         pd = ($urandom_range(3) == 0) ? int'($urandom_range(1023)) : int'($urandom_range(15));
         pf = int'($urandom_range(1023));
         pw = int'($urandom_range(1023));
         send(int'($urandom), 1'b0, 16'h0);
         repeat ($urandom_range(2)) @(negedge clk);
      end

      // reset while a sample is in flight, buffer holding nonzero data
      bus.sample_in       = 16'sh2222;
      bus.pot_delay       = 10'd3;
      bus.sample_in_valid = 1'b1;
      @(negedge clk);
      bus.sample_in_valid = 1'b0;
      @(negedge clk);
      do_reset(1'b0);

      pd = 5; pf = 0; pw = 1023;
      send('h1234, 1'b1, 16'h1234);

      // maximum delay across the write-pointer wrap
      pd = 1023; pf = 0; pw = 1023;
      for (int k = 0; k < NB + 40; k++) send(((k * 37) % 20000) - 10000, 1'b0, 16'h0);

      w = 0;
      while (sb.size() > 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      checkint("pending_outputs", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
